nios_avalon_st_adapter_data_format_adapter_0: RTL and testbench
===============================================================

NIOS_AVALON_ST_ADAPTER_DATA_FORMAT_ADAPTER_0 -- requirements
Module: nios_avalon_st_adapter_data_format_adapter_0

Interface
REQ-001 Parameter SYMBOL_ORDER_BE, default 1, meaning: 1 = in_data[31:24] is sent first, 0 = in_data[7:0] is sent first.
REQ-002 Design SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_ready  output  1  sink ready; 32-bit word accepted when in_valid && in_ready.
REQ-006 in_valid  input  1  sink word valid.
REQ-007 in_data  input  32  four 8-bit symbols.
REQ-008 in_error  input  6  per-word error flags.
REQ-009 in_startofpacket  input  1  word is the first word of a packet.
REQ-010 in_endofpacket  input  1  word is the last word of a packet.
REQ-011 in_empty  input  2  unused trailing symbols; meaningful only with in_endofpacket.
REQ-012 out_ready  input  1  downstream ready; byte transferred when out_valid && out_ready.
REQ-013 out_valid  output  1  source byte valid.
REQ-014 out_data  output  8  current symbol.
REQ-015 out_error  output  6  error flags of the word the byte came from.
REQ-016 out_startofpacket  output  1  first byte of packet.
REQ-017 out_endofpacket  output  1  last valid byte of packet.

Function
REQ-018 Block SHALL hold one word in a register: data, error, sop, eop and empty, plus a full flag and a 2-bit symbol index idx.
REQ-019 last_idx SHALL be 3 - empty when the held word has eop=1, and 3 otherwise; in_empty on words with eop=0 SHALL be ignored.
REQ-020 out_valid SHALL equal full; out_data SHALL be symbol idx in SYMBOL_ORDER_BE order.
REQ-021 out_startofpacket SHALL be held sop && idx==0; out_endofpacket SHALL be held eop && idx==last_idx.
REQ-022 out_error SHALL equal held error on every byte of the word.
REQ-023 in_ready SHALL be combinational: !full || (out_ready && idx==last_idx).
REQ-024 On a byte transfer with idx!=last_idx, idx SHALL increment by 1 and the word is retained.
REQ-025 On a transfer at idx==last_idx: if a new word is accepted in the same cycle, the block SHALL load it with idx=0 and full=1; otherwise full SHALL go to 0.
REQ-026 On acceptance while empty, the block SHALL load the word with idx=0; the first byte SHALL appear on the next cycle (latency 1).
REQ-027 Sustained throughput SHALL be one byte per cycle with no bubble between words.
REQ-028 While out_valid && !out_ready, all out_* signals SHALL stay stable.
REQ-029 eop=1 with empty=3 SHALL emit exactly one byte carrying both sop/eop as applicable; a single-word packet with empty=0 SHALL emit 4 bytes.
REQ-030 The block SHALL NOT check packet framing; SOP/EOP SHALL be passed through as received.

Reset
REQ-031 When reset=1 at a clock edge, the block SHALL set full=0, idx=0 and clear held sideband; out_valid SHALL be 0 in the following cycle.
REQ-032 During reset, in_ready SHALL be 1 (!full) but words SHALL NOT be captured; reset mid-packet SHALL discard the held word silently.
REQ-033 Reset values: out_valid=0, out_startofpacket=0, out_endofpacket=0, out_error=0, out_data=0.

Configuration
REQ-034 Macro NIOS_DFA_ERROR_EN defined: the block SHALL register in_error and drive out_error as in REQ-022.
REQ-035 Macro undefined: the block SHALL ignore in_error, SHALL NOT build the error register, and SHALL tie out_error to 0.

Verification
REQ-036 Word 0xAABBCCDD, sop=1, eop=1, empty=0, out_ready=1, BE=1 -> bytes AA,BB,CC,DD on 4 consecutive cycles; sop on AA, eop on DD.
REQ-037 Two back-to-back words (0x01020304 sop, 0x05060708 eop, empty=2), out_ready=1 -> 01..04,05,06 on 6 consecutive cycles; in_ready high on cycle 4 for the second word.
REQ-038 out_ready toggled 1,0,0,1 mid-word -> out_data and out_* stable while low; no byte lost or duplicated.
REQ-039 eop=1, empty=3, data 0x11223344, BE=0 -> single byte 0x44 with sop and eop both set.
REQ-040 reset pulsed after 2 of 4 bytes -> out_valid=0 next cycle; the next packet starts cleanly at idx 0.
REQ-041 in_error=6'h2A: with NIOS_DFA_ERROR_EN, 0x2A on all 4 bytes; without it, out_error=0.

Source files
------------

// File: rtl/nios_avalon_st_adapter_data_format_adapter_0.sv
// Avalon-ST 32-bit to 8-bit symbol serializer: one held word, emitted one symbol per cycle.
// Optional macro NIOS_DFA_ERROR_EN carries in_error through to out_error; undefined ties it to 0.
module nios_avalon_st_adapter_data_format_adapter_0 #(
  parameter int SYMBOL_ORDER_BE = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [31:0] in_data,
  input  logic [5:0] in_error,
  input  logic       in_startofpacket,
  input  logic       in_endofpacket,
  input  logic [1:0] in_empty,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [5:0] out_error,
  output logic       out_startofpacket,
  output logic       out_endofpacket
);

  // Handshake: a word moves in when in_valid && in_ready, a byte moves out when
  // out_valid && out_ready; neither side waits on the other's valid to assert ready.
  logic [31:0] data_q;
  logic        sop_q;
  logic        eop_q;
  logic [1:0]  empty_q;
  logic        full_q;
  logic [1:0]  idx_q;

  logic [1:0]  last_idx;
  logic [1:0]  sym_sel;
  logic        at_last;
  logic        byte_xfer;
  logic        accept;

  // empty_q is only loaded for eop words, so it is zero otherwise.
  assign last_idx  = eop_q ? (2'd3 - empty_q) : 2'd3;
  assign at_last   = (idx_q == last_idx);
  assign byte_xfer = full_q && out_ready;
  assign in_ready  = !full_q || (out_ready && at_last);
  assign accept    = in_valid && in_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      full_q  <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      data_q  <= in_data;
      sop_q   <= in_startofpacket;
      eop_q   <= in_endofpacket;
      empty_q <= in_endofpacket ? in_empty : 2'd0;
      full_q  <= 1'b1;
      idx_q   <= '0;
    end else if (byte_xfer) begin
      if (at_last) begin
        full_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        idx_q  <= idx_q + 2'd1;
      end
    end
  end

`ifdef NIOS_DFA_ERROR_EN
  logic [5:0] error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= '0;
    end else if (accept) begin
      error_q <= in_error;
    end
  end

  assign out_error = error_q;
`else
  logic unused_in_error;
  assign unused_in_error = ^in_error;
  assign out_error       = 6'd0;
`endif

  // Big-endian order sends in_data[31:24] as symbol 0.
  assign sym_sel = (SYMBOL_ORDER_BE != 0) ? (2'd3 - idx_q) : idx_q;

  always_comb begin
    out_data = 8'd0;
    case (sym_sel)
      2'd0: out_data = data_q[7:0];
      2'd1: out_data = data_q[15:8];
      2'd2: out_data = data_q[23:16];
      2'd3: out_data = data_q[31:24];
      default: out_data = 8'd0;
    endcase
  end

  assign out_valid         = full_q;
  assign out_startofpacket = sop_q && (idx_q == 2'd0);
  assign out_endofpacket   = eop_q && at_last;

endmodule

// File: tb/tb_nios_avalon_st_adapter_data_format_adapter_0.sv
// Directed bench for the 32-to-8 serializer: big-endian and little-endian instances share stimulus.
module tb_nios_avalon_st_adapter_data_format_adapter_0;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [5:0]  in_error;
  logic        in_sop;
  logic        in_eop;
  logic [1:0]  in_empty;
  logic        out_ready;

  logic        in_ready, out_valid, out_sop, out_eop;
  logic [7:0]  out_data;
  logic [5:0]  out_error;

  logic        le_in_ready, le_out_valid, le_out_sop, le_out_eop;
  logic [7:0]  le_out_data;
  logic [5:0]  le_out_error;

  int checks = 0;
  int errors = 0;

`ifdef NIOS_DFA_ERROR_EN
  localparam logic [5:0] ERR_EXP = 6'h2A;
`else
  localparam logic [5:0] ERR_EXP = 6'h00;
`endif

  nios_avalon_st_adapter_data_format_adapter_0 #(.SYMBOL_ORDER_BE(1)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_error(in_error), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .in_empty(in_empty), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop)
  );

  nios_avalon_st_adapter_data_format_adapter_0 #(.SYMBOL_ORDER_BE(0)) dut_le (
    .clk(clk), .reset(reset), .in_ready(le_in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_error(in_error), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .in_empty(in_empty), .out_ready(out_ready),
    .out_valid(le_out_valid), .out_data(le_out_data), .out_error(le_out_error),
    .out_startofpacket(le_out_sop), .out_endofpacket(le_out_eop)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] d, input logic sop,
                            input logic eop, input logic [5:0] err);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
    chk({tag, "_sop"}, {31'd0, out_sop}, {31'd0, sop});
    chk({tag, "_eop"}, {31'd0, out_eop}, {31'd0, eop});
    chk({tag, "_err"}, {26'd0, out_error}, {26'd0, err});
  endtask

  task automatic drive_word(input logic [31:0] d, input logic sop, input logic eop,
                            input logic [1:0] emp, input logic [5:0] err);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = sop;
    in_eop   = eop;
    in_empty = emp;
    in_error = err;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_empty = 2'd0;
    in_error = 6'd0;
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    idle();
    step();
    step();

    // Reset values
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sop", {31'd0, out_sop}, 32'd0);
    chk("rst_eop", {31'd0, out_eop}, 32'd0);
    chk("rst_err", {26'd0, out_error}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    // Single 4-byte word, both symbol orders
    drive_word(32'hAABBCCDD, 1'b1, 1'b1, 2'd0, 6'd0);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    idle();
    check_byte("t1_b0", 8'hAA, 1'b1, 1'b0, 6'd0);
    chk("t1_le_b0", {24'd0, le_out_data}, 32'hDD);
    step();
    check_byte("t1_b1", 8'hBB, 1'b0, 1'b0, 6'd0);
    chk("t1_le_b1", {24'd0, le_out_data}, 32'hCC);
    step();
    check_byte("t1_b2", 8'hCC, 1'b0, 1'b0, 6'd0);
    chk("t1_le_b2", {24'd0, le_out_data}, 32'hBB);
    step();
    check_byte("t1_b3", 8'hDD, 1'b0, 1'b1, 6'd0);
    chk("t1_le_b3", {24'd0, le_out_data}, 32'hAA);
    chk("t1_le_eop", {31'd0, le_out_eop}, 32'd1);
    step();
    chk("t1_done", {31'd0, out_valid}, 32'd0);

    // Back-to-back words, second with empty=2
    drive_word(32'h01020304, 1'b1, 1'b0, 2'd3, 6'd0);
    step();
    drive_word(32'h05060708, 1'b0, 1'b1, 2'd2, 6'd0);
    check_byte("t2_b0", 8'h01, 1'b1, 1'b0, 6'd0);
    chk("t2_rdy0", {31'd0, in_ready}, 32'd0);
    step();
    check_byte("t2_b1", 8'h02, 1'b0, 1'b0, 6'd0);
    chk("t2_rdy1", {31'd0, in_ready}, 32'd0);
    step();
    check_byte("t2_b2", 8'h03, 1'b0, 1'b0, 6'd0);
    step();
    check_byte("t2_b3", 8'h04, 1'b0, 1'b0, 6'd0);
    chk("t2_rdy3", {31'd0, in_ready}, 32'd1);
    step();
    idle();
    check_byte("t2_b4", 8'h05, 1'b0, 1'b0, 6'd0);
    step();
    check_byte("t2_b5", 8'h06, 1'b0, 1'b1, 6'd0);
    step();
    chk("t2_done", {31'd0, out_valid}, 32'd0);

    // Backpressure mid-word
    drive_word(32'h10203040, 1'b1, 1'b1, 2'd0, 6'd0);
    step();
    idle();
    check_byte("t3_b0", 8'h10, 1'b1, 1'b0, 6'd0);
    step();
    out_ready = 1'b0;
    check_byte("t3_b1", 8'h20, 1'b0, 1'b0, 6'd0);
    chk("t3_rdy_low", {31'd0, in_ready}, 32'd0);
    step();
    check_byte("t3_hold1", 8'h20, 1'b0, 1'b0, 6'd0);
    step();
    check_byte("t3_hold2", 8'h20, 1'b0, 1'b0, 6'd0);
    out_ready = 1'b1;
    step();
    check_byte("t3_b2", 8'h30, 1'b0, 1'b0, 6'd0);
    step();
    check_byte("t3_b3", 8'h40, 1'b0, 1'b1, 6'd0);
    step();
    chk("t3_done", {31'd0, out_valid}, 32'd0);

    // empty=3 single byte
    drive_word(32'h11223344, 1'b1, 1'b1, 2'd3, 6'd0);
    step();
    idle();
    chk("t4_le_valid", {31'd0, le_out_valid}, 32'd1);
    chk("t4_le_data", {24'd0, le_out_data}, 32'h44);
    chk("t4_le_sop", {31'd0, le_out_sop}, 32'd1);
    chk("t4_le_eop", {31'd0, le_out_eop}, 32'd1);
    check_byte("t4_be", 8'h11, 1'b1, 1'b1, 6'd0);
    step();
    chk("t4_le_done", {31'd0, le_out_valid}, 32'd0);
    chk("t4_done", {31'd0, out_valid}, 32'd0);

    // Reset mid-packet
    drive_word(32'hA1B2C3D4, 1'b1, 1'b1, 2'd0, 6'd0);
    step();
    idle();
    check_byte("t5_b0", 8'hA1, 1'b1, 1'b0, 6'd0);
    step();
    check_byte("t5_b1", 8'hB2, 1'b0, 1'b0, 6'd0);
    step();
    check_byte("t5_b2", 8'hC3, 1'b0, 1'b0, 6'd0);
    reset = 1'b1;
    step();
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_data", {24'd0, out_data}, 32'd0);
    chk("t5_rst_sop", {31'd0, out_sop}, 32'd0);
    chk("t5_rst_eop", {31'd0, out_eop}, 32'd0);
    drive_word(32'hDEADBEEF, 1'b1, 1'b1, 2'd0, 6'd0);
    chk("t5_rst_rdy", {31'd0, in_ready}, 32'd1);
    step();
    reset = 1'b0;
    idle();
    chk("t5_no_capture", {31'd0, out_valid}, 32'd0);
    drive_word(32'h55667788, 1'b1, 1'b1, 2'd1, 6'd0);
    step();
    idle();
    check_byte("t5_n0", 8'h55, 1'b1, 1'b0, 6'd0);
    step();
    check_byte("t5_n1", 8'h66, 1'b0, 1'b0, 6'd0);
    step();
    check_byte("t5_n2", 8'h77, 1'b0, 1'b1, 6'd0);
    step();
    chk("t5_done", {31'd0, out_valid}, 32'd0);

    // Error flags across a word
    drive_word(32'hC0FFEE11, 1'b1, 1'b1, 2'd0, 6'h2A);
    step();
    idle();
    check_byte("t6_b0", 8'hC0, 1'b1, 1'b0, ERR_EXP);
    step();
    check_byte("t6_b1", 8'hFF, 1'b0, 1'b0, ERR_EXP);
    step();
    check_byte("t6_b2", 8'hEE, 1'b0, 1'b0, ERR_EXP);
    step();
    check_byte("t6_b3", 8'h11, 1'b0, 1'b1, ERR_EXP);
    step();
    chk("t6_done", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
